csr_counter: RTL and testbench
==============================

# csr_counter

Parametrised counter CSR for the Hippomenes core. It holds a free-running event counter of 1 to 64 bits, exposed as a low half and an optional high half at two CSR addresses. It is the counting successor to the single-register `csr`, intended for `mcycle`/`minstret`-style counters and timer sources, and it adds a sticky overflow flag. It sits beside the other CSRs on the shared CSR access bus (enable, address, op, operand) and reports the old value combinationally for read-modify-write instructions.

## Interface
- `CounterWidth`, 64: counter width in bits, legal range 1..64.
- `ResetValue`, 0: counter value after reset, `CounterWidth` bits.
- `AddrLo`, `CsrAddrT'(0)`: CSR address of bits [min(W,32)-1:0].
- `AddrHi`, `CsrAddrT'(0)`: CSR address of bits [W-1:32]. Only meaningful when W>32.
- `Write`, 1: if 0, CSR instructions cannot modify the counter (read-only counter).
- Reset is synchronous and active-high. There is one clock, `clk`; all state updates on its rising edge. `reset` is sampled only at that edge.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `csr_enable`  in  1  CSR instruction valid this cycle
- `csr_addr`  in  `CsrAddrT`  CSR address
- `csr_op`  in  `csr_op_t`  CSRRW/RS/RC/RWI/RSI/RCI
- `rs1_zimm`  in  `r`  rs1 index, or the zimm immediate for the I-variants
- `rs1_data`  in  `word`  rs1 operand
- `inc`  in  1  count event this cycle
- `inhibit`  in  1  when 1, `inc` is ignored (`mcountinhibit` bit)
- `ext_data`  in  `CounterWidth`  full-width external load value
- `ext_write_enable`  in  1  load `ext_data` this cycle
- `overflow_clear`  in  1  clear the overflow flag
- `out`  out  `word`  old value of the addressed half, zero-extended; 0 if the address does not match
- `direct_out`  out  `word`  next value of the addressed half; 0 if the address does not match
- `overflow`  out  1  sticky wrap-around flag

## Operation
- Internal state: counter `V` (W bits) and flag `ovf`.
- **Half mapping.** `lo = V[min(W,32)-1:0]`, zero-extended to 32 bits. `hi = V[W-1:32]` when W>32, zero-extended.
- **AddrHi when W<=32.** The high half does not exist. Reads return 0 and writes are ignored.
- **Effective write.** Occurs when `csr_enable`, the address matches, and `Write`=1, and one of the following holds:
  - op is CSRRW or CSRRWI;
  - op is RS/RC/RSI/RCI and `rs1_zimm`≠0.
- **Write operand.** `rs1_data` for RW/RS/RC; zero-extended `rs1_zimm` for the I-variants.
- **New half value.**
  - RW: operand.
  - RS: old | operand.
  - RC: old & ~operand.
  - The result is truncated to the half's width.
  - The other half is unchanged.
- **Count enable.** `cnt = inc & ~inhibit`.
- **Next-state priority, highest first:**
  1. `reset`: V=ResetValue, ovf=0.
  2. `ext_write_enable`: V=ext_data. No count this cycle.
  3. Effective CSR write to either half: the write applies and the count is suppressed for the whole counter this cycle.
  4. `cnt`: V=V+1 mod 2^W, with the carry propagating from lo into hi.
- **Overflow.**
  - ovf is set in the cycle where rule 4 applies with V = all-ones, so V wraps to 0.
  - `overflow_clear` clears ovf.
  - If set and clear happen in the same cycle, set wins.
  - CSR and external writes never change ovf, even when they write all-ones or zero.
- `overflow` = ovf, registered.
- `direct_out` reflects priority rules 2–4 for the addressed half, so it can be consumed as a side-effect value, matching `csr`.

## Timing
- **Reset values.** V=ResetValue and `overflow`=0 one edge after `reset`=1. `out` and `direct_out` follow combinationally.
- **Latency.**
  - `out` is combinational from the current V and address (zero cycles).
  - The updated value is visible on `out` the cycle after the write or increment edge.
- **Counting.** Continuous `cnt` increments V by exactly 1 per cycle. There is no multi-cycle carry; the full-width add completes in one cycle.
- **Mid-operation reset.** Reset in any cycle overrides a simultaneous write, increment, or clear.
- **Write-then-count.** A CSR write at edge k gives V=written value after k. Counting resumes from that value at edge k+1 if `cnt` is held.

## Test plan
- **Reset and basic count.** W=64, ResetValue=0: reset 1 cycle, then `inc`=1 for 5 cycles -> lo reads 5, hi reads 0, `overflow`=0.
- **Write wins over count.** CSRRW to AddrLo with `rs1_data`=0x100 while `inc`=1 -> `out`=old value in that cycle. After the edge, lo=0x100, not 0x101. The next cycle counts to 0x101.
- **Carry into high half.** W=40, ext load 0x00_FFFF_FFFF, then one `inc` -> hi=1, lo=0. Further increments to 0xFF_FFFF_FFFF, then one more `inc` -> V=0 and `overflow`=1.
- **Overflow flag.**
  - W=8 at 0xFF: `inc` together with `overflow_clear` -> V=0, `overflow`=1 (set wins).
  - Next cycle, `overflow_clear` alone -> 0.
  - `inc` with `inhibit`=1 -> V unchanged.
- **Set/clear ops and zero operand.**
  - CSRRS with `rs1_zimm`=0 and `inc`=1 -> no write, and the count still happens.
  - CSRRCI with zimm=0x3 on lo=0xF -> lo=0xC.
- **Absent or read-only half.**
  - W=32: CSRRW to AddrHi with 0xDEAD -> `out`=0, and V is unchanged apart from counting.
  - `Write`=0: CSRRW to AddrLo -> lo keeps counting.

Source files
------------

// File: rtl/csr_counter_if.sv
// CSR access bus shared by the CSR blocks of the core: the instruction side
// drives enable/address/op/operands, each CSR answers with its old value
// (out) and the value it will hold after this cycle (direct_out).

package csr_counter_pkg;
    typedef logic [11:0] CsrAddrT;
    typedef logic [4:0]  r;
    typedef logic [31:0] word;

    // Encodings follow the funct3 field of the RISC-V Zicsr instructions.
    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;
endpackage

interface csr_counter_if;
    logic                      csr_enable;
    csr_counter_pkg::CsrAddrT  csr_addr;
    csr_counter_pkg::csr_op_t  csr_op;
    csr_counter_pkg::r         rs1_zimm;
    csr_counter_pkg::word      rs1_data;
    csr_counter_pkg::word      out;
    csr_counter_pkg::word      direct_out;

    modport master (
        output csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        input  out, direct_out
    );

    modport slave (
        input  csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        output out, direct_out
    );
endinterface

// File: rtl/csr_counter.sv
// Free-running event counter CSR (1..64 bits) exposed as a low word and an
// optional high word, with a sticky wrap-around flag. Loads from an external
// source beat CSR writes, and CSR writes beat counting for the whole counter.

module csr_counter
    import csr_counter_pkg::*;
#(
    parameter int                      CounterWidth = 64,
    parameter logic [CounterWidth-1:0] ResetValue   = '0,
    parameter CsrAddrT                 AddrLo       = CsrAddrT'(0),
    parameter CsrAddrT                 AddrHi       = CsrAddrT'(0),
    parameter bit                      Write        = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    csr_counter_if.slave            csr,
    input  logic                    inc,
    input  logic                    inhibit,
    input  logic [CounterWidth-1:0] ext_data,
    input  logic                    ext_write_enable,
    input  logic                    overflow_clear,
    output logic                    overflow
);

    // The high word only exists for counters wider than one CSR word.
    localparam bit HasHi = CounterWidth > 32;

    logic [CounterWidth-1:0] value_reg;
    logic [CounterWidth-1:0] value_next;
    logic                    ovf_reg;
    logic                    ovf_next;

    // Both the current and next counter values are viewed zero-padded to 64
    // bits so the half selection below is identical for every width.
    logic [63:0] value_ext;
    logic [63:0] next_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_pad
            if (gi < CounterWidth) begin : g_bit
                assign value_ext[gi] = value_reg[gi];
                assign next_ext[gi]  = value_next[gi];
            end else begin : g_zero
                assign value_ext[gi] = 1'b0;
                assign next_ext[gi]  = 1'b0;
            end
        end
    endgenerate

    logic        sel_lo;
    logic        sel_hi;
    logic        op_rw;
    logic        op_set;
    logic        op_clr;
    logic        op_imm;
    logic        csr_write;
    logic        cnt_en;
    logic [31:0] operand;
    logic [31:0] old_half;
    logic [31:0] new_half;
    logic [63:0] write_ext;

    // Decode the CSR access: which half is addressed, whether it really
    // writes (set/clear with a zero source are pure reads), and the new half.
    always_comb begin
        sel_lo   = (csr.csr_addr == AddrLo);
        sel_hi   = HasHi && (csr.csr_addr == AddrHi) && !sel_lo;
        op_rw    = (csr.csr_op == CSRRW) || (csr.csr_op == CSRRWI);
        op_set   = (csr.csr_op == CSRRS) || (csr.csr_op == CSRRSI);
        op_clr   = (csr.csr_op == CSRRC) || (csr.csr_op == CSRRCI);
        op_imm   = (csr.csr_op == CSRRWI) || (csr.csr_op == CSRRSI) ||
                   (csr.csr_op == CSRRCI);
        operand  = op_imm ? {27'b0, csr.rs1_zimm} : csr.rs1_data;

        old_half = 32'h0;
        if (sel_lo) begin
            old_half = value_ext[31:0];
        end else if (sel_hi) begin
            old_half = value_ext[63:32];
        end

        csr_write = csr.csr_enable && (sel_lo || sel_hi) && Write &&
                    (op_rw || ((op_set || op_clr) && (csr.rs1_zimm != '0)));

        if (op_rw) begin
            new_half = operand;
        end else if (op_set) begin
            new_half = old_half | operand;
        end else begin
            new_half = old_half & ~operand;
        end

        // Bits above the counter width fall away in the truncation below.
        if (sel_hi) begin
            write_ext = {new_half, value_ext[31:0]};
        end else begin
            write_ext = {value_ext[63:32], new_half};
        end
    end

    // Next counter value and overflow flag: external load, then CSR write,
    // then counting. Only a counting wrap can set the flag; set beats clear.
    always_comb begin
        cnt_en     = inc & ~inhibit;
        value_next = value_reg;
        ovf_next   = ovf_reg & ~overflow_clear;
        if (ext_write_enable) begin
            value_next = ext_data;
        end else if (csr_write) begin
            value_next = write_ext[CounterWidth-1:0];
        end else if (cnt_en) begin
            value_next = value_reg + CounterWidth'(1);
            if (&value_reg) begin
                ovf_next = 1'b1;
            end
        end
    end

    // Counter and flag registers; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= ResetValue;
            ovf_reg   <= 1'b0;
        end else begin
            value_reg <= value_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Read-back of the addressed half: old value and post-update value.
    always_comb begin
        csr.out        = old_half;
        csr.direct_out = 32'h0;
        if (sel_lo) begin
            csr.direct_out = next_ext[31:0];
        end else if (sel_hi) begin
            csr.direct_out = next_ext[63:32];
        end
    end

    assign overflow = ovf_reg;

endmodule

// File: tb/tb_csr_counter.sv
// Bench for csr_counter: five parameterisations share one stimulus stream and
// are each checked against an arithmetic model of the counter value and flag.

module tb_csr_counter;
    import csr_counter_pkg::*;

    localparam int          ND        = 5;
    localparam int          WS  [ND]  = '{64, 40, 8, 32, 16};
    localparam logic [63:0] RVS [ND]  = '{64'h0, 64'h12_3456_789A, 64'hA5, 64'h0, 64'h0};
    localparam bit          WRS [ND]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam CsrAddrT     ALO       = 12'hB00;
    localparam CsrAddrT     AHI       = 12'hB80;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_enable;
    CsrAddrT     csr_addr;
    csr_op_t     csr_op;
    r            rs1_zimm;
    word         rs1_data;
    logic        inc;
    logic        inhibit;
    logic [63:0] ext_data;
    logic        ext_we;
    logic        ovf_clr;

    word  out_a  [ND];
    word  dout_a [ND];
    logic ovf_a  [ND];

    int checks = 0;
    int errors = 0;

    // Model state: counter value (masked to its width) and sticky flag.
    logic [63:0] mv [ND];
    bit          mo [ND];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            csr_counter_if bus ();
            assign bus.csr_enable = csr_enable;
            assign bus.csr_addr   = csr_addr;
            assign bus.csr_op     = csr_op;
            assign bus.rs1_zimm   = rs1_zimm;
            assign bus.rs1_data   = rs1_data;
            assign out_a[gi]      = bus.out;
            assign dout_a[gi]     = bus.direct_out;

            csr_counter #(
                .CounterWidth (WS[gi]),
                .ResetValue   (RVS[gi][WS[gi]-1:0]),
                .AddrLo       (ALO),
                .AddrHi       (AHI),
                .Write        (WRS[gi])
            ) dut (
                .clk              (clk),
                .reset            (reset),
                .csr              (bus),
                .inc              (inc),
                .inhibit          (inhibit),
                .ext_data         (ext_data[WS[gi]-1:0]),
                .ext_write_enable (ext_we),
                .overflow_clear   (ovf_clr),
                .overflow         (ovf_a[gi])
            );
        end
    endgenerate

    function automatic logic [63:0] msk(int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic bit eff_wr(int d);
        bit hit;
        bit rw;
        bit sc;
        hit = (csr_addr == ALO) || ((csr_addr == AHI) && (WS[d] > 32));
        rw  = (csr_op == CSRRW) || (csr_op == CSRRWI);
        sc  = !rw;
        return csr_enable && hit && WRS[d] && (rw || (sc && rs1_zimm != 5'd0));
    endfunction

    // Counter value after this edge ignoring reset: load, CSR write, count.
    function automatic logic [63:0] exp_next(int d);
        logic [63:0] v;
        logic [31:0] opnd;
        logic [31:0] oldh;
        logic [31:0] newh;
        bit          hi;
        v = mv[d];
        if (ext_we) return ext_data & msk(WS[d]);
        if (eff_wr(d)) begin
            hi   = (csr_addr == AHI);
            opnd = (csr_op == CSRRWI || csr_op == CSRRSI || csr_op == CSRRCI) ?
                   {27'd0, rs1_zimm} : rs1_data;
            oldh = hi ? v[63:32] : v[31:0];
            case (csr_op)
                CSRRW, CSRRWI: newh = opnd;
                CSRRS, CSRRSI: newh = oldh | opnd;
                default:       newh = oldh & ~opnd;
            endcase
            v = hi ? {newh, v[31:0]} : {v[63:32], newh};
            return v & msk(WS[d]);
        end
        if (inc && !inhibit) return (v + 64'd1) & msk(WS[d]);
        return v;
    endfunction

    function automatic bit exp_ovf(int d);
        bit set;
        set = !ext_we && !eff_wr(d) && inc && !inhibit && (mv[d] == msk(WS[d]));
        return set || (mo[d] && !ovf_clr);
    endfunction

    function automatic word exp_half(int d, logic [63:0] v);
        if (csr_addr == ALO) return v[31:0];
        if (csr_addr == AHI && WS[d] > 32) return v[63:32];
        return 32'h0;
    endfunction

    task automatic idle();
        reset      = 1'b0;
        csr_enable = 1'b0;
        csr_addr   = ALO;
        csr_op     = CSRRW;
        rs1_zimm   = 5'd0;
        rs1_data   = 32'h0;
        inc        = 1'b0;
        inhibit    = 1'b0;
        ext_data   = 64'h0;
        ext_we     = 1'b0;
        ovf_clr    = 1'b0;
    endtask

    // Advance one clock edge, updating the model with the inputs seen there.
    task automatic tick();
        logic [63:0] nv [ND];
        bit          no [ND];
        for (int d = 0; d < ND; d++) begin
            nv[d] = reset ? (RVS[d] & msk(WS[d])) : exp_next(d);
            no[d] = reset ? 1'b0 : exp_ovf(d);
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            mv[d] = nv[d];
            mo[d] = no[d];
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; inc = 1'b1; ext_we = 1'b1; ext_data = 64'h5555_AAAA_5555_AAAA;
        csr_enable = 1'b1; rs1_data = 32'h1234;
        tick();
        idle();
        #2;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_a[d] !== exp_half(d, RVS[d] & msk(WS[d]))) begin
                errors++;
                $display("FAIL reset_lo dut%0d got %h expected %h", d, out_a[d], exp_half(d, RVS[d] & msk(WS[d])));
            end
            checks++;
            if (ovf_a[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ovf dut%0d got %b expected 0", d, ovf_a[d]);
            end
        end
        csr_addr = AHI;
        #1;
        checks++;
        if (out_a[1] !== 32'h12) begin
            errors++;
            $display("FAIL reset_hi dut1 got %h expected 00000012", out_a[1]);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_count();
        idle();
        reset = 1'b1;
        tick();
        idle();
        inc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle();
        #2;
        checks++;
        if (out_a[0] !== 32'd5) begin
            errors++;
            $display("FAIL count_lo dut0 got %h expected 00000005", out_a[0]);
        end
        checks++;
        if (out_a[2] !== 32'hAA) begin
            errors++;
            $display("FAIL count_lo dut2 got %h expected 000000aa", out_a[2]);
        end
        csr_addr = AHI;
        #1;
        checks++;
        if (out_a[0] !== 32'd0 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL count_hi dut0 got %h/%b expected 00000000/0", out_a[0], ovf_a[0]);
        end
        $display("test_basic_count done");
    endtask

    task automatic test_write_wins();
        idle();
        csr_enable = 1'b1; csr_op = CSRRW; rs1_data = 32'h100; inc = 1'b1;
        #2;
        checks++;
        if (out_a[0] !== 32'd5 || dout_a[0] !== 32'h100) begin
            errors++;
            $display("FAIL write_cycle dut0 got %h/%h expected 00000005/00000100", out_a[0], dout_a[0]);
        end
        tick();
        idle();
        inc = 1'b1;
        #2;
        checks++;
        if (out_a[0] !== 32'h100) begin
            errors++;
            $display("FAIL write_no_count dut0 got %h expected 00000100", out_a[0]);
        end
        checks++;
        if (out_a[4] !== 32'd6) begin
            errors++;
            $display("FAIL ro_counts dut4 got %h expected 00000006", out_a[4]);
        end
        tick();
        inc = 1'b0;
        #2;
        checks++;
        if (out_a[0] !== 32'h101) begin
            errors++;
            $display("FAIL write_then_count dut0 got %h expected 00000101", out_a[0]);
        end
        $display("test_write_wins done");
    endtask

    task automatic test_carry();
        idle();
        ext_we = 1'b1; ext_data = 64'h00_FFFF_FFFF;
        tick();
        idle();
        inc = 1'b1;
        tick();
        idle();
        csr_addr = AHI;
        #2;
        checks++;
        if (out_a[1] !== 32'd1) begin
            errors++;
            $display("FAIL carry_hi dut1 got %h expected 00000001", out_a[1]);
        end
        csr_addr = ALO;
        #1;
        checks++;
        if (out_a[1] !== 32'd0) begin
            errors++;
            $display("FAIL carry_lo dut1 got %h expected 00000000", out_a[1]);
        end
        ext_we = 1'b1; ext_data = 64'hFF_FFFF_FFFE;
        tick();
        idle();
        inc = 1'b1;
        tick();
        #1;
        checks++;
        if (ovf_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early dut1 got %b expected 0", ovf_a[1]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (out_a[1] !== 32'd0 || ovf_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap40 dut1 got %h/%b expected 00000000/1", out_a[1], ovf_a[1]);
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (ovf_a[d] !== mo[d]) begin
                errors++;
                $display("FAIL carry_ovf dut%0d got %b expected %b", d, ovf_a[d], mo[d]);
            end
        end
        $display("test_carry done");
    endtask

    task automatic test_overflow();
        idle();
        ovf_clr = 1'b1;
        tick();
        idle();
        ext_we = 1'b1; ext_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        idle();
        inc = 1'b1; ovf_clr = 1'b1;
        tick();
        idle();
        #2;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (ovf_a[d] !== 1'b1 || out_a[d] !== 32'd0) begin
                errors++;
                $display("FAIL set_beats_clear dut%0d got %h/%b expected 00000000/1", d, out_a[d], ovf_a[d]);
            end
        end
        ovf_clr = 1'b1;
        tick();
        idle();
        #2;
        checks++;
        if (ovf_a[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear dut2 got %b expected 0", ovf_a[2]);
        end
        inc = 1'b1; inhibit = 1'b1;
        tick();
        idle();
        #2;
        checks++;
        if (out_a[2] !== 32'd0) begin
            errors++;
            $display("FAIL inhibit dut2 got %h expected 00000000", out_a[2]);
        end
        $display("test_overflow done");
    endtask

    task automatic test_set_clear();
        idle();
        csr_enable = 1'b1; csr_op = CSRRS; rs1_zimm = 5'd0; rs1_data = 32'hFFFF_FFFF; inc = 1'b1;
        tick();
        idle();
        #2;
        checks++;
        if (out_a[0] !== 32'd1) begin
            errors++;
            $display("FAIL rs_zero dut0 got %h expected 00000001", out_a[0]);
        end
        csr_enable = 1'b1; csr_op = CSRRW; rs1_data = 32'hF;
        tick();
        csr_op = CSRRCI; rs1_zimm = 5'd3; rs1_data = 32'hFFFF_FFFF;
        tick();
        idle();
        #2;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_a[d] !== (WRS[d] ? 32'hC : 32'd1)) begin
                errors++;
                $display("FAIL rci dut%0d got %h expected %h", d, out_a[d], (WRS[d] ? 32'hC : 32'd1));
            end
        end
        $display("test_set_clear done");
    endtask

    task automatic test_absent_hi();
        idle();
        csr_enable = 1'b1; csr_addr = AHI; csr_op = CSRRW; rs1_data = 32'hDEAD; inc = 1'b1;
        #2;
        checks++;
        if (out_a[3] !== 32'd0 || dout_a[3] !== 32'd0) begin
            errors++;
            $display("FAIL absent_read dut3 got %h/%h expected 00000000/00000000", out_a[3], dout_a[3]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (out_a[3] !== 32'hD) begin
            errors++;
            $display("FAIL absent_count dut3 got %h expected 0000000d", out_a[3]);
        end
        csr_addr = AHI;
        #1;
        checks++;
        if (out_a[0] !== 32'hDEAD) begin
            errors++;
            $display("FAIL hi_write dut0 got %h expected 0000dead", out_a[0]);
        end
        $display("test_absent_hi done");
    endtask

    task automatic test_back_to_back();
        idle();
        csr_enable = 1'b1; csr_op = CSRRW; rs1_data = 32'h500; inc = 1'b1;
        tick();
        csr_enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        idle();
        #2;
        checks++;
        if (out_a[0] !== 32'h503) begin
            errors++;
            $display("FAIL write_then_run dut0 got %h expected 00000503", out_a[0]);
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_a[d] !== exp_half(d, mv[d])) begin
                errors++;
                $display("FAIL b2b_model dut%0d got %h expected %h", d, out_a[d], exp_half(d, mv[d]));
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random(int n);
        csr_op_t ops [6] = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};
        for (int i = 0; i < n; i++) begin
            idle();
            reset      = ($urandom_range(0, 63) == 0);
            ext_we     = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       ext_data = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
                1:       ext_data = 64'h0000_0000_FFFF_FFFF - 64'($urandom_range(0, 2));
                default: ext_data = {$urandom, $urandom};
            endcase
            csr_enable = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       csr_addr = ALO;
                1:       csr_addr = AHI;
                default: csr_addr = CsrAddrT'($urandom);
            endcase
            csr_op   = ops[$urandom_range(0, 5)];
            rs1_zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : r'($urandom);
            rs1_data = $urandom;
            inc      = ($urandom_range(0, 3) != 0);
            inhibit  = ($urandom_range(0, 7) == 0);
            ovf_clr  = ($urandom_range(0, 7) == 0);
            #2;
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (out_a[d] !== exp_half(d, mv[d])) begin
                    errors++;
                    $display("FAIL rnd_out cyc%0d dut%0d got %h expected %h", i, d, out_a[d], exp_half(d, mv[d]));
                end
                checks++;
                if (dout_a[d] !== exp_half(d, exp_next(d))) begin
                    errors++;
                    $display("FAIL rnd_direct cyc%0d dut%0d got %h expected %h", i, d, dout_a[d], exp_half(d, exp_next(d)));
                end
            end
            tick();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (ovf_a[d] !== mo[d]) begin
                    errors++;
                    $display("FAIL rnd_ovf cyc%0d dut%0d got %b expected %b", i, d, ovf_a[d], mo[d]);
                end
            end
        end
        $display("test_random done cycles %0d", n);
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_count();
        test_write_wins();
        test_carry();
        test_overflow();
        test_set_clear();
        test_absent_hi();
        test_back_to_back();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
